ble_tx_serializer: RTL and testbench
====================================

BLE_TX_SERIALIZER -- requirements
Module: ble_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, FIFO word width in bits (power of two).
REQ-002 SHALL have parameter CNT_WIDTH, default 17, width of the bit-length field and bit counter.
REQ-003 SHALL have port R_CLK  input  1  read-domain clock; all state changes on its rising edge.
REQ-004 SHALL have port R_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin transmission of one packet.
REQ-006 SHALL have port data_size  input  CNT_WIDTH  packet length in bits, sampled on accepted start.
REQ-007 SHALL have port R_empty  input  1  FIFO empty flag from the read-pointer stage.
REQ-008 SHALL have port R_data  input  DATA_WIDTH  FIFO word at the current read address, valid combinationally.
REQ-009 SHALL have port bit_stb  input  1  one-cycle symbol-rate strobe, one per transmitted bit.
REQ-010 SHALL have port R_inc  output  1  FIFO pop request to the read-pointer stage.
REQ-011 SHALL have port tx_bit  output  1  registered serial data bit to the modulator.
REQ-012 SHALL have port tx_valid  output  1  one-cycle pulse when tx_bit updates.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port tx_irq  output  1  one-cycle packet-complete pulse.
REQ-015 SHALL have port underrun  output  1  sticky FIFO-starvation flag.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, SHIFT and DONE.
REQ-017 IDLE: start with data_size!=0 latches data_size, clears bit_cnt and the pending strobe, and moves to FETCH.
REQ-018 IDLE: start with data_size==0 moves to DONE without popping the FIFO.
REQ-019 start SHALL be ignored whenever busy=1.
REQ-020 FETCH: R_inc = (state==FETCH) & ~R_empty, combinational; on that edge load shreg<=R_data, word_left<=DATA_WIDTH and move to SHIFT.
REQ-021 FETCH with R_empty=1: hold state with R_inc=0.
REQ-022 bit_stb arriving in FETCH SHALL set a one-deep pending flag that is consumed as a strobe in the first SHIFT cycle; a second strobe while pending is already set is lost.
REQ-023 SHIFT: on a strobe (bit_stb or pending), tx_bit<=shreg[0] (LSB first), shreg>>=1, word_left-=1, bit_cnt+=1, tx_valid=1 for that cycle.
REQ-024 SHIFT: after a strobe, bit_cnt+1==latched size moves to DONE, else word_left==1 moves to FETCH, else stay in SHIFT.
REQ-025 Unsent bits of the final word SHALL be discarded; no extra pop occurs.
REQ-026 DONE: tx_irq=1 for exactly one cycle, then move to IDLE.
REQ-027 tx_bit SHALL hold its last value between strobes and in IDLE.
REQ-028 bit_cnt SHALL be CNT_WIDTH bits wide and never wrap; the maximum packet is 2^CNT_WIDTH-1 bits.
REQ-029 At most one R_inc SHALL be issued per DATA_WIDTH transmitted bits.

Reset
REQ-030 R_rst_n low SHALL asynchronously force state=IDLE, R_inc=0, tx_bit=0, tx_valid=0, busy=0, tx_irq=0, underrun=0, shreg=0, bit_cnt=0, and clear the pending flag.
REQ-031 Reset asserted mid-packet SHALL abandon the packet without issuing tx_irq.

Configuration
REQ-032 Macro BLE_TX_UNDERRUN_EN defined: bit_stb in FETCH with R_empty=1 sets underrun, moves to IDLE with no tx_irq, and underrun clears only on an accepted start or reset.
REQ-033 Macro BLE_TX_UNDERRUN_EN undefined: underrun is tied to 0, FETCH stalls per REQ-021, and the strobe is handled per REQ-022.

Verification
REQ-034 Reset, data_size=40, FIFO words 0xA5A5A5A5 and 0x000000FF, strobe every 8 cycles -> 40 tx_valid pulses, bits 1,0,1,0,0,1,0,1... for word 0, then 8 ones, exactly 2 R_inc, one tx_irq, busy low after it.
REQ-035 start with data_size=0 -> tx_irq one cycle later, R_inc never asserted, tx_valid never asserted.
REQ-036 data_size=64 and strobe arriving in the same cycle as the second R_inc -> pending flag consumed, 64 pulses, no bit lost.
REQ-037 FIFO empty at the second word with BLE_TX_UNDERRUN_EN defined -> after 32 bits, underrun=1, state IDLE, no tx_irq; without the macro -> stall, then resume when R_empty falls and complete with tx_irq.
REQ-038 R_rst_n pulsed low after 10 bits of a 100-bit packet -> all outputs at reset values immediately, no tx_irq; a fresh start then transmits normally.
REQ-039 start re-asserted while busy -> ignored, with bit count and data unchanged.

Source files
------------

// File: rtl/ble_tx_serializer.sv
// BLE TX serializer: pops FIFO words and shifts them out LSB first on the symbol strobe.
// Optional BLE_TX_UNDERRUN_EN: a strobe while FETCH sees an empty FIFO aborts the packet and sets underrun.
//   state | meaning
//   IDLE  | waiting for start
//   FETCH | popping the next FIFO word
//   SHIFT | sending word bits on each strobe
//   DONE  | one-cycle packet-complete pulse
module ble_tx_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 17
) (
  input  logic                  R_CLK,
  input  logic                  R_rst_n,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  data_size,
  input  logic                  R_empty,
  input  logic [DATA_WIDTH-1:0] R_data,
  input  logic                  bit_stb,
  output logic                  R_inc,
  output logic                  tx_bit,
  output logic                  tx_valid,
  output logic                  busy,
  output logic                  tx_irq,
  output logic                  underrun
);

  localparam int WL_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  size_q, size_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_inc;
  logic [WL_W-1:0]       word_left_q, word_left_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  pend_q, pend_d;
  logic                  tx_bit_q, tx_bit_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  underrun_q, underrun_d;
  logic                  strobe;

  assign bit_cnt_inc = bit_cnt_q + CNT_WIDTH'(1);
  assign strobe      = bit_stb | pend_q;

  always_ff @(posedge R_CLK or negedge R_rst_n) begin
    if (!R_rst_n) begin
      state_q     <= S_IDLE;
      size_q      <= '0;
      bit_cnt_q   <= '0;
      word_left_q <= '0;
      shreg_q     <= '0;
      pend_q      <= 1'b0;
      tx_bit_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      bit_cnt_q   <= bit_cnt_d;
      word_left_q <= word_left_d;
      shreg_q     <= shreg_d;
      pend_q      <= pend_d;
      tx_bit_q    <= tx_bit_d;
      tx_valid_q  <= tx_valid_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    bit_cnt_d   = bit_cnt_q;
    word_left_d = word_left_q;
    shreg_d     = shreg_q;
    pend_d      = pend_q;
    tx_bit_d    = tx_bit_q;
    tx_valid_d  = 1'b0;
    underrun_d  = underrun_q;
    R_inc       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          underrun_d = 1'b0;
          if (data_size != '0) begin
            size_d    = data_size;
            bit_cnt_d = '0;
            pend_d    = 1'b0;
            state_d   = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end

      S_FETCH: begin
        if (!R_empty) begin
          R_inc       = 1'b1;
          shreg_d     = R_data;
          word_left_d = WL_W'(DATA_WIDTH);
          state_d     = S_SHIFT;
          if (bit_stb) pend_d = 1'b1;
        end else if (bit_stb) begin
`ifdef BLE_TX_UNDERRUN_EN
          underrun_d = 1'b1;
          pend_d     = 1'b0;
          state_d    = S_IDLE;
`else
          pend_d = 1'b1;
`endif
        end
      end

      S_SHIFT: begin
        if (strobe) begin
          pend_d      = 1'b0;
          tx_bit_d    = shreg_q[0];
          tx_valid_d  = 1'b1;
          shreg_d     = shreg_q >> 1;
          word_left_d = word_left_q - WL_W'(1);
          bit_cnt_d   = bit_cnt_inc;
          // Remaining bits of a partial last word are simply dropped.
          if (bit_cnt_inc == size_q)
            state_d = S_DONE;
          else if (word_left_q == WL_W'(1))
            state_d = S_FETCH;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_irq   = (state_q == S_DONE);
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ble_tx_serializer.sv
// Self-checking bench for ble_tx_serializer: table vectors, hand sequences and random packets
// checked against a bit-stream model built from the FIFO contents.
module tb_ble_tx_serializer;
  localparam int DW = 32;
  localparam int CW = 17;

  typedef struct {
    int          size;
    int          period;
    int          avail_dly;
    int          restart_at;
    int          exp_pulses;
    int          exp_pops;
    int          exp_irq;
    int          exp_und;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  logic          R_CLK = 1'b0;
  logic          R_rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] data_size = '0;
  logic          R_empty;
  logic [DW-1:0] R_data;
  logic          bit_stb = 1'b0;
  logic          R_inc, tx_bit, tx_valid, busy, tx_irq, underrun;

  logic [DW-1:0] mem [0:15];
  int            rd = 0;
  int            avail = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic          s_inc, s_val, s_bit, s_irq, s_busy, s_und;
  vec_t          vecs [9];

  always #5 R_CLK = ~R_CLK;

  assign R_empty = (rd >= avail);
  assign R_data  = (rd < 16) ? mem[rd[3:0]] : '0;

  ble_tx_serializer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .R_CLK(R_CLK), .R_rst_n(R_rst_n), .start(start), .data_size(data_size),
    .R_empty(R_empty), .R_data(R_data), .bit_stb(bit_stb), .R_inc(R_inc),
    .tx_bit(tx_bit), .tx_valid(tx_valid), .busy(busy), .tx_irq(tx_irq),
    .underrun(underrun)
  );

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Packet bit i is bit (i mod 32) of FIFO word (i div 32), LSB first.
  function automatic logic model_bit(int i);
    logic [DW-1:0] w;
    if (i >= 16 * DW) return 1'bx;
    w = mem[i / DW];
    return w[i % DW];
  endfunction

  task automatic step(input logic stb_v, input logic st_v, input logic [CW-1:0] sz_v);
    @(negedge R_CLK);
    bit_stb   = stb_v;
    start     = st_v;
    data_size = sz_v;
    #1;
    s_inc  = R_inc;
    s_val  = tx_valid;
    s_bit  = tx_bit;
    s_irq  = tx_irq;
    s_busy = busy;
    s_und  = underrun;
    @(posedge R_CLK);
    #1;
    if (s_inc) rd++;
  endtask

  task automatic run_pkt(input vec_t v, input string tag);
    int   c, pulses, pops, irqs, bad_bits, nw, budget;
    logic done;
    nw       = (v.size + DW - 1) / DW;
    mem[0]   = v.w0;
    mem[1]   = v.w1;
    for (int i = 2; i < 16; i++) mem[i] = $urandom;
    rd       = 0;
    avail    = (v.avail_dly > 0) ? 1 : nw;
    pulses   = 0;
    pops     = 0;
    irqs     = 0;
    bad_bits = 0;
    done     = 1'b0;
    budget   = v.size * v.period * 2 + v.avail_dly + 200;
    step(1'b0, 1'b1, CW'(v.size));
    c = 1;
    while (!done && c < budget) begin
      step(((c % v.period) == v.period - 1), (c == v.restart_at),
           (c == v.restart_at) ? CW'(5) : CW'(0));
      if (v.avail_dly > 0 && c >= v.avail_dly) avail = nw;
      if (c == 1) check({tag, "_underrun_cleared"}, s_und, 0);
      if (s_val) begin
        if (s_bit !== model_bit(pulses)) bad_bits++;
        pulses++;
      end
      pops += int'(s_inc);
      irqs += int'(s_irq);
      if (!s_busy) done = 1'b1;
      c++;
    end
    check({tag, "_finished"}, done, 1);
    check({tag, "_pulses"}, pulses, v.exp_pulses);
    check({tag, "_bit_errors"}, bad_bits, 0);
    check({tag, "_pops"}, pops, v.exp_pops);
    check({tag, "_irq_cycles"}, irqs, v.exp_irq);
    check({tag, "_underrun"}, s_und, v.exp_und);
  endtask

  initial begin
    int   pulses, irqs, sz;
    vec_t rv;

    vecs[0] = '{40, 8, 0, 0, 40, 2, 1, 0, 32'hA5A5A5A5, 32'h000000FF};
    vecs[1] = '{0, 3, 0, 0, 0, 0, 1, 0, 32'h12345678, 32'h9ABCDEF0};
    vecs[2] = '{1, 2, 0, 0, 1, 1, 1, 0, 32'hFFFFFFFF, 32'h0};
    vecs[3] = '{32, 1, 0, 0, 32, 1, 1, 0, 32'h80000001, 32'hFFFFFFFF};
    vecs[4] = '{33, 4, 0, 0, 33, 2, 1, 0, 32'h0F0F0F0F, 32'hFFFFFFFE};
    vecs[5] = '{64, 1, 0, 0, 64, 2, 1, 0, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[6] = '{40, 5, 0, 60, 40, 2, 1, 0, 32'h3C3C3C3C, 32'h000000AA};
`ifdef BLE_TX_UNDERRUN_EN
    vecs[7] = '{64, 8, 400, 0, 32, 1, 0, 1, 32'h76543210, 32'hFEDCBA98};
`else
    vecs[7] = '{64, 8, 400, 0, 64, 2, 1, 0, 32'h76543210, 32'hFEDCBA98};
`endif
    vecs[8] = '{100, 3, 0, 0, 100, 4, 1, 0, 32'h5A5A5A5A, 32'h00FF00FF};

    for (int i = 0; i < 16; i++) mem[i] = '0;
    #12;
    check("reset_R_inc", R_inc, 0);
    check("reset_tx_bit", tx_bit, 0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_irq", tx_irq, 0);
    check("reset_underrun", underrun, 0);
    @(negedge R_CLK);
    R_rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_pkt(vecs[i], $sformatf("vec%0d", i));

    // Reset asserted after 10 bits of a 100-bit packet.
    for (int i = 0; i < 16; i++) mem[i] = 32'hFFFFFFFF;
    rd     = 0;
    avail  = 4;
    pulses = 0;
    irqs   = 0;
    step(1'b0, 1'b1, CW'(100));
    for (int c = 1; c < 2000 && pulses < 10; c++) begin
      step(((c % 4) == 3), 1'b0, '0);
      pulses += int'(s_val);
      irqs   += int'(s_irq);
    end
    check("midrst_bits_before", pulses, 10);
    @(negedge R_CLK);
    R_rst_n = 1'b0;
    #1;
    check("midrst_R_inc", R_inc, 0);
    check("midrst_tx_bit", tx_bit, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tx_irq", tx_irq, 0);
    check("midrst_underrun", underrun, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge R_CLK);
      #1;
      irqs += int'(tx_irq);
    end
    check("midrst_no_irq", irqs, 0);
    @(negedge R_CLK);
    R_rst_n = 1'b1;
    rv = '{50, 2, 0, 0, 50, 2, 1, 0, 32'hC3C3C3C3, 32'h1234ABCD};
    run_pkt(rv, "after_rst");

    for (int k = 0; k < 15; k++) begin
      sz = int'($urandom_range(1, 160));
      rv = '{sz, int'($urandom_range(1, 6)), 0, 0, sz, (sz + DW - 1) / DW, 1, 0,
             $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rv.restart_at = int'($urandom_range(2, 20));
      run_pkt(rv, $sformatf("rand%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
